// File: rtl/rx_bit_timer.sv
// rx_bit_timer: receive bit-timing unit for the serial receivers.
// A free-running phase counter, resynchronised by every line transition,
// produces one sample strobe per bit. Sampled bits are counted into frames
// and a frame-complete pulse is issued. Too many bit periods without a
// transition (edge starvation) moves the unit into an error state that is
// held until reception ends.
//
// Ports:
//   clk            system clock
//   n_rst          asynchronous active-low reset
//   d_edge         single-cycle pulse on a detected line transition
//   rcving         high while a frame/packet is being received
//   clks_per_bit   clocks per bit period (latched at start of reception)
//   sample_pt      phase at which the bit is sampled (latched)
//   bits_per_frame bits per frame, 0 means 2^BITS_W (latched)
//   shift_enable   one-cycle sample strobe
//   byte_received  one-cycle frame-complete pulse
//   bit_cnt        bits sampled in the current frame
//   stuff_err      high while in the error state
module rx_bit_timer #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned BITS_W  = 4,
  parameter int unsigned MAX_RUN = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              d_edge,
  input  logic              rcving,
  input  logic [CNT_W-1:0]  clks_per_bit,
  input  logic [CNT_W-1:0]  sample_pt,
  input  logic [BITS_W-1:0] bits_per_frame,
  output logic              shift_enable,
  output logic              byte_received,
  output logic [BITS_W-1:0] bit_cnt,
  output logic              stuff_err
);

  localparam int unsigned GAP_W = (MAX_RUN < 1) ? 1 : $clog2(MAX_RUN + 1);

  localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  TWO_C   = CNT_W'(2);
  localparam logic [BITS_W-1:0] ONE_B   = BITS_W'(1);
  localparam logic [BITS_W:0]   BPF_ONE = (BITS_W + 1)'(1);
  localparam logic [GAP_W-1:0]  ONE_G   = GAP_W'(1);
  localparam logic [GAP_W-1:0]  GAP_MAX = GAP_W'(MAX_RUN);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  phase;
  logic [CNT_W-1:0]  cpb, sp;
  logic [BITS_W:0]   bpf;        // one extra bit so 2^BITS_W is representable
  logic [BITS_W-1:0] bit_cnt_q;
  logic [GAP_W-1:0]  gap;
  logic              byte_q;

  logic [CNT_W-1:0]  cpb_in, sp_in;
  logic [BITS_W:0]   bpf_in;
  logic              last_bit, gap_full, stuff_hit;

  // Configuration as it will be latched on entry to RUN.
  always_comb begin
    cpb_in = (clks_per_bit < TWO_C) ? TWO_C : clks_per_bit;
    sp_in  = (sample_pt > cpb_in - ONE_C) ? cpb_in - ONE_C : sample_pt;
    bpf_in = (bits_per_frame == '0) ? {1'b1, {BITS_W{1'b0}}}
                                    : {1'b0, bits_per_frame};
  end

  assign shift_enable  = (state == RUN) && (phase == sp);
  assign last_bit      = ({1'b0, bit_cnt_q} == bpf - BPF_ONE);
  assign gap_full      = (gap == GAP_MAX);
  // A coincident edge rescues the bit: it clears gap with priority.
  assign stuff_hit     = shift_enable && gap_full && !d_edge;

  assign byte_received = byte_q;
  assign bit_cnt       = bit_cnt_q;
  assign stuff_err     = (state == ERR);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rcving) state_nxt = RUN;
      RUN: begin
        if (!rcving)        state_nxt = IDLE;
        else if (stuff_hit) state_nxt = ERR;
      end
      ERR:  if (!rcving) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase     <= '0;
      bit_cnt_q <= '0;
      gap       <= '0;
      cpb       <= '0;
      sp        <= '0;
      bpf       <= '0;
      byte_q    <= 1'b0;
    end else begin
      byte_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rcving) begin
            phase     <= '0;
            bit_cnt_q <= '0;
            gap       <= '0;
            cpb       <= cpb_in;
            sp        <= sp_in;
            bpf       <= bpf_in;
          end
        end
        RUN: begin
          if (!rcving) begin
            // Partial frame is dropped; a strobe in this cycle is not counted.
            phase     <= '0;
            bit_cnt_q <= '0;
            gap       <= '0;
          end else begin
            if (d_edge)                   phase <= '0;
            else if (phase == cpb - ONE_C) phase <= '0;
            else                          phase <= phase + ONE_C;

            if (shift_enable && !stuff_hit) begin
              if (last_bit) begin
                bit_cnt_q <= '0;
                byte_q    <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + ONE_B;
              end
            end

            if (d_edge)                         gap <= '0;
            else if (shift_enable && !gap_full) gap <= gap + ONE_G;
          end
        end
        ERR: begin
          if (!rcving) begin
            phase     <= '0;
            bit_cnt_q <= '0;
            gap       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_bit_timer.sv
// Self-checking bench for rx_bit_timer: directed scenarios plus randomized
// reception bursts, compared every cycle against a behavioural model that
// tracks time since the last resync and bit/gap counts arithmetically.
module tb_rx_bit_timer;

  localparam int BITS_W  = 4;
  localparam int MAX_RUN = 6;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_edge = 1'b0;
  logic       rcving = 1'b0;
  logic [3:0] clks_per_bit = 4'd8;
  logic [3:0] sample_pt = 4'd3;
  logic [3:0] bits_per_frame = 4'd8;
  logic       shift_enable, byte_received, stuff_err;
  logic [3:0] bit_cnt;

  rx_bit_timer #(.CNT_W(4), .BITS_W(BITS_W), .MAX_RUN(MAX_RUN)) dut (
    .clk(clk), .n_rst(n_rst), .d_edge(d_edge), .rcving(rcving),
    .clks_per_bit(clks_per_bit), .sample_pt(sample_pt),
    .bits_per_frame(bits_per_frame), .shift_enable(shift_enable),
    .byte_received(byte_received), .bit_cnt(bit_cnt), .stuff_err(stuff_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit m_run, m_err, m_byte;
  int m_cpb, m_sp, m_bpf, m_since, m_bits, m_gap;

  // Directed-scenario bookkeeping
  int first_se, byte_at, bc_at_byte, se_count, err_at, next_se, len;
  bit byte_seen;

  function automatic bit m_strobe();
    if (!m_run) return 1'b0;
    return (m_since % m_cpb) == m_sp;
  endfunction

  task automatic model_reset();
    m_run = 0; m_err = 0; m_byte = 0;
    m_since = 0; m_bits = 0; m_gap = 0;
  endtask

  task automatic model_update(input bit de, input bit rc, input bit se);
    m_byte = 0;
    if (m_err) begin
      if (!rc) begin m_err = 0; m_bits = 0; end
    end else if (!m_run) begin
      if (rc) begin
        m_cpb   = (clks_per_bit < 2) ? 2 : int'(clks_per_bit);
        m_sp    = (int'(sample_pt) > m_cpb - 1) ? m_cpb - 1 : int'(sample_pt);
        m_bpf   = (bits_per_frame == 0) ? (1 << BITS_W) : int'(bits_per_frame);
        m_since = 0; m_bits = 0; m_gap = 0; m_run = 1;
      end
    end else if (!rc) begin
      m_run = 0; m_bits = 0;
    end else if (se && m_gap == MAX_RUN && !de) begin
      m_run = 0; m_err = 1;
    end else begin
      if (se) begin
        m_bits++;
        if (m_bits == m_bpf) begin m_bits = 0; m_byte = 1; end
      end
      if (de) m_gap = 0;
      else if (se) m_gap++;
      m_since = de ? 0 : m_since + 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic check_outputs();
    chk("shift_enable", 32'(shift_enable), 32'(m_strobe()));
    chk("byte_received", 32'(byte_received), 32'(m_byte));
    chk("bit_cnt", 32'(bit_cnt), 32'(m_bits));
    chk("stuff_err", 32'(stuff_err), 32'(m_err));
  endtask

  // Apply inputs for one cycle, advance model at the edge, check #1 after.
  task automatic step(input logic de, input logic rc);
    bit se_pre;
    se_pre = m_strobe();
    d_edge = de;
    rcving = rc;
    @(posedge clk);
    if (!n_rst) model_reset();
    else        model_update(de, rc, se_pre);
    #1;
    check_outputs();
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_se", 32'(shift_enable), 32'd0);
    chk("reset_byte", 32'(byte_received), 32'd0);
    chk("reset_bitcnt", 32'(bit_cnt), 32'd0);
    chk("reset_err", 32'(stuff_err), 32'd0);
    n_rst = 1'b1;
    step(1'b0, 1'b0);

    // Legacy timing: edge every bit period on the last phase.
    clks_per_bit = 4'd8; sample_pt = 4'd3; bits_per_frame = 4'd8;
    step(1'b0, 1'b1);
    first_se = -1; byte_at = -1; bc_at_byte = -1;
    for (int i = 1; i <= 64; i++) begin
      step(((i - 1) % 8) == 7, 1'b1);
      if (shift_enable && first_se < 0) first_se = i;
      if (byte_received && byte_at < 0) begin byte_at = i; bc_at_byte = int'(bit_cnt); end
    end
    chk("legacy_first_strobe", first_se, 3);
    chk("legacy_byte_at", byte_at, 60);
    chk("legacy_bitcnt_wrap", bc_at_byte, 0);
    step(1'b0, 1'b0);

    // Resync: edge during phase 5 of bit 2 (cycle 21); phase restarts next
    // cycle so the strobe lands at 22+3=25 rather than 27.
    step(1'b0, 1'b1);
    next_se = -1;
    for (int i = 1; i <= 30; i++) begin
      step((i - 1) == 21, 1'b1);
      if (shift_enable && i > 22 && next_se < 0) next_se = i;
    end
    chk("resync_strobe", next_se, 25);
    step(1'b0, 1'b0);

    // Edge starvation: single edge at start, strobes from cycle 4 every 8.
    step(1'b0, 1'b1);
    se_count = 0; err_at = -1;
    for (int i = 1; i <= 80; i++) begin
      step(i == 1, 1'b1);
      if (shift_enable) se_count++;
      if (stuff_err && err_at < 0) err_at = i;
    end
    chk("stuff_strobes", se_count, 7);
    chk("stuff_err_at", err_at, 53);
    step(1'b0, 1'b0);
    chk("stuff_clear", 32'(stuff_err), 32'd0);

    // Config clamping: cpb->2, sp->1, bpf->16.
    clks_per_bit = 4'd1; sample_pt = 4'd9; bits_per_frame = 4'd0;
    step(1'b0, 1'b1);
    se_count = 0; byte_at = -1;
    for (int i = 1; i <= 40; i++) begin
      step(((i - 1) % 2) == 1, 1'b1);
      if (byte_received && byte_at < 0) byte_at = i;
      if (shift_enable && byte_at < 0) se_count++;
    end
    chk("clamp_strobes", se_count, 16);
    chk("clamp_byte_at", byte_at, 32);
    step(1'b0, 1'b0);

    // Abort after 5 bits, then restart with a different config.
    clks_per_bit = 4'd8; sample_pt = 4'd3; bits_per_frame = 4'd8;
    step(1'b0, 1'b1);
    byte_seen = 0;
    for (int i = 1; i <= 37; i++) begin
      step(((i - 1) % 8) == 7, 1'b1);
      if (byte_received) byte_seen = 1;
    end
    chk("abort_bits_before", 32'(bit_cnt), 32'd5);
    step(1'b0, 1'b0);
    chk("abort_no_byte", 32'(byte_seen || byte_received), 32'd0);
    chk("abort_bitcnt", 32'(bit_cnt), 32'd0);
    clks_per_bit = 4'd4; sample_pt = 4'd2; bits_per_frame = 4'd3;
    step(1'b0, 1'b1);
    byte_at = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b1);
      if (byte_received && byte_at < 0) byte_at = i;
    end
    chk("restart_byte_at", byte_at, 11);
    step(1'b0, 1'b0);

    // Asynchronous reset mid-frame, during a strobe cycle.
    clks_per_bit = 4'd8; sample_pt = 4'd3; bits_per_frame = 4'd8;
    step(1'b0, 1'b1);
    for (int i = 1; i <= 11; i++) step(1'b0, 1'b1);
    chk("pre_reset_strobe", 32'(shift_enable), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    chk("async_rst_se", 32'(shift_enable), 32'd0);
    chk("async_rst_bitcnt", 32'(bit_cnt), 32'd0);
    chk("async_rst_byte", 32'(byte_received), 32'd0);
    chk("async_rst_err", 32'(stuff_err), 32'd0);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    n_rst = 1'b1;
    step(1'b0, 1'b0);

    // Randomized bursts with random configuration and sparse edges.
    for (int it = 0; it < 10; it++) begin
      clks_per_bit   = 4'($urandom_range(0, 15));
      sample_pt      = 4'($urandom_range(0, 15));
      bits_per_frame = 4'($urandom_range(0, 15));
      len = int'($urandom_range(20, 150));
      for (int j = 0; j < len; j++) step($urandom_range(0, 4) == 0, 1'b1);
      len = int'($urandom_range(1, 3));
      for (int j = 0; j < len; j++) step($urandom_range(0, 1) == 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
